// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared pipeline constants and fetch queue entry type
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_RESET  = 32'h3000;
    localparam logic [31:0] IM_LO     = 32'h3000;
    localparam logic [31:0] IM_HI     = 32'h6FFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fq_entry_t;

    // Fetch address error: misaligned or outside instruction memory
    function automatic logic pc_is_adel(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
    endfunction

endpackage

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - fetch queue entry array, one write port, one async read port
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  fq_entry_t        wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output fq_entry_t        rd_data
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction queue with redirect flush
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_pc,
    input  logic [31:0]      enq_instr,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      deq_pc,
    output logic [31:0]      deq_instr,
    output logic             deq_adel,
    input  logic             flush,
    input  logic             flush_keep_slot,
    output logic [PTR_W:0]   count
);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W:0]   remain;
    fq_entry_t        wr_entry;
    fq_entry_t        head;
    fq_entry_t        head_sel;
    logic             enq_fire;
    logic             deq_fire;
    logic             bypass_take;
    logic             store_enq;
    logic             pop;

    assign enq_ready = (count < (PTR_W+1)'(DEPTH));
    assign wr_entry  = '{pc: enq_pc, instr: enq_instr, adel: pc_is_adel(enq_pc)};

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass      = (count == '0) && enq_valid;
    assign deq_valid   = (count != '0) || bypass;
    assign head_sel    = bypass ? wr_entry : head;
    assign bypass_take = bypass && deq_ready;
`else
    assign deq_valid   = (count != '0);
    assign head_sel    = head;
    assign bypass_take = 1'b0;
`endif

    // Empty queue presents a nop bubble to decode
    assign deq_pc    = deq_valid ? head_sel.pc    : 32'h0;
    assign deq_instr = deq_valid ? head_sel.instr : NOP_INSTR;
    assign deq_adel  = deq_valid ? head_sel.adel  : 1'b0;

    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;
    // A bypassed-and-consumed entry never touches the storage or pointers
    assign store_enq = enq_fire && !bypass_take;
    assign pop       = deq_fire && !bypass_take;
    assign rd_next   = rd_ptr + PTR_W'(pop);
    assign remain    = count - (PTR_W+1)'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            if (flush_keep_slot && (remain != '0)) begin
                rd_ptr <= rd_next;
                wr_ptr <= rd_next + PTR_W'(1);
                count  <= (PTR_W+1)'(1);
            end else if (flush_keep_slot && store_enq) begin
                // Queue drained this cycle; the incoming entry is the delay slot
                rd_ptr <= wr_ptr;
                wr_ptr <= wr_ptr + PTR_W'(1);
                count  <= (PTR_W+1)'(1);
            end else begin
                rd_ptr <= rd_next;
                wr_ptr <= rd_next;
                count  <= '0;
            end
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_ptr + PTR_W'(store_enq);
            count  <= remain + (PTR_W+1)'(store_enq);
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (store_enq),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

endmodule
